im_fetch_ctrl: RTL and testbench

- Fetch sequencer in front of the combinational instruction memory (word-indexed ROM, 32-bit instructions).
- Owns the program counter and issues IM addresses.
- Registers instruction/PC toward decode with a valid/ready handshake; handles branch/jump redirects, run/halt control and range faults.
- Shares the IM address port with a debug read port, so a monitor can dump program memory while the core is idle.

---
 rtl/im_fetch_ctrl.sv | 128 ++++++++++++
 tb/tb_im_fetch_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_fetch_ctrl.sv
// Fetch sequencer for a combinational word-indexed instruction ROM: owns the PC,
// delivers instructions to decode over valid/ready, and shares the ROM port with a debug reader.
module im_fetch_ctrl #(
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 IM_WORDS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              clear_fault,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [31:0]       im_instr,
  output logic              f_valid,
  input  logic              f_ready,
  output logic [31:0]       f_instr,
  output logic [ADDR_W-1:0] f_pc,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [31:0]       dbg_rdata,
  output logic [1:0]        state,
  output logic              fault
);

  typedef enum logic [1:0] {
    S_HALT  = 2'b00,
    S_RUN   = 2'b01,
    S_FAULT = 2'b10
  } state_t;

  // One extra bit so the byte limit never aliases with a wrapped PC.
  localparam logic [ADDR_W:0] PC_LIMIT = (ADDR_W+1)'(IM_WORDS * 4);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;

  logic w_inRange;
  logic w_slotFree;
  logic w_fetchOpp;
  logic w_issue;
  logic w_rangeFault;
  logic w_redirAccept;
  logic w_misaligned;
  logic w_dbgGrant;

  assign w_inRange     = {1'b0, r_pc} < PC_LIMIT;
  assign w_slotFree    = !f_valid || f_ready;
  assign w_fetchOpp    = (r_state == S_RUN) && !redirect_valid && w_slotFree;
  assign w_issue       = w_fetchOpp && run && w_inRange;
  assign w_rangeFault  = w_fetchOpp && !w_inRange;
  assign w_redirAccept = redirect_valid && (r_state != S_FAULT);
  assign w_misaligned  = redirect_pc[1:0] != 2'b00;
  assign w_dbgGrant    = !w_issue && dbg_req;

  assign state = r_state;
  assign fault = (r_state == S_FAULT);

  always_comb begin
    im_addr = '0;
    if (w_issue) begin
      im_addr = r_pc >> 2;
    end else if (w_dbgGrant) begin
      im_addr = dbg_addr;
    end
  end

  // A redirect squashes the instruction register; a misaligned target faults without touching the PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_HALT;
      r_pc      <= RESET_PC;
      f_valid   <= 1'b0;
      f_instr   <= '0;
      f_pc      <= '0;
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      dbg_ack <= w_dbgGrant;
      if (w_dbgGrant) begin
        dbg_rdata <= im_instr;
      end

      if (w_redirAccept) begin
        f_valid <= 1'b0;
        if (w_misaligned) begin
          r_state <= S_FAULT;
        end else begin
          r_pc <= redirect_pc;
          if (r_state == S_HALT && run) begin
            r_state <= S_RUN;
          end else if (r_state == S_RUN && !run) begin
            r_state <= S_HALT;
          end
        end
      end else begin
        if (w_issue) begin
          f_instr <= im_instr;
          f_pc    <= r_pc;
          f_valid <= 1'b1;
          r_pc    <= r_pc + ADDR_W'(4);
        end else if (f_valid && f_ready) begin
          f_valid <= 1'b0;
        end

        case (r_state)
          S_HALT: begin
            if (run) r_state <= S_RUN;
          end
          S_RUN: begin
            if (w_rangeFault) begin
              r_state <= S_FAULT;
            end else if (!run) begin
              r_state <= S_HALT;
            end
          end
          S_FAULT: begin
            if (clear_fault) r_state <= S_HALT;
          end
          default: r_state <= S_HALT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Scenario bench for im_fetch_ctrl: a random ROM image, directed scenarios and a
// randomized run checked against a program-order stream model.
module tb_im_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        run;
  logic        clear_fault;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] im_addr;
  logic [31:0] im_instr;
  logic        f_valid;
  logic        f_ready;
  logic [31:0] f_instr;
  logic [15:0] f_pc;
  logic        dbg_req;
  logic [15:0] dbg_addr;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic [1:0]  state;
  logic        fault;

  logic [31:0] mem [32];
  int total;
  int bad;

  im_fetch_ctrl #(.ADDR_W(16), .RESET_PC(16'h0000), .IM_WORDS(32)) dut (
    .clk(clk), .rst(rst), .run(run), .clear_fault(clear_fault),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .im_addr(im_addr), .im_instr(im_instr),
    .f_valid(f_valid), .f_ready(f_ready), .f_instr(f_instr), .f_pc(f_pc),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .state(state), .fault(fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ROM beyond the valid range returns a recognisable tag so stray reads are visible.
  always_comb begin
    if (im_addr < 16'd32) im_instr = mem[im_addr[4:0]];
    else                  im_instr = {16'hBAD0, im_addr};
  end

  function automatic logic [31:0] romWord(input logic [15:0] idx);
    if (idx < 16'd32) return mem[idx[4:0]];
    return {16'hBAD0, idx};
  endfunction

  task automatic idleInputs();
    run = 0; clear_fault = 0; redirect_valid = 0; redirect_pc = 0;
    f_ready = 0; dbg_req = 0; dbg_addr = 0;
  endtask

  task automatic doReset();
    idleInputs();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    idleInputs();
    rst = 1;
    #1;
    total++; if (state !== 2'b00) begin bad++; $display("FAIL reset_state got=%b want=00", state); end
    total++; if (f_valid !== 1'b0) begin bad++; $display("FAIL reset_fvalid got=%b want=0", f_valid); end
    total++; if (f_instr !== 32'h0 || f_pc !== 16'h0) begin bad++; $display("FAIL reset_freg got=%h/%h want=0/0", f_instr, f_pc); end
    total++; if (dbg_ack !== 1'b0 || dbg_rdata !== 32'h0) begin bad++; $display("FAIL reset_dbg got=%b/%h want=0/0", dbg_ack, dbg_rdata); end
    total++; if (fault !== 1'b0 || im_addr !== 16'h0) begin bad++; $display("FAIL reset_misc got=%b/%h want=0/0", fault, im_addr); end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_stream();
    doReset();
    run = 1; f_ready = 1;
    @(negedge clk); #1;
    total++; if (f_valid !== 1'b0 || im_addr !== 16'h0) begin bad++; $display("FAIL stream_issue got=%b/%h want=0/0", f_valid, im_addr); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      total++;
      if (f_valid !== 1'b1 || f_pc !== 16'(i * 4) || f_instr !== mem[i]) begin
        bad++; $display("FAIL stream_word%0d got=%b/%h/%h want=1/%h/%h", i, f_valid, f_pc, f_instr, 16'(i * 4), mem[i]);
      end
    end
  endtask

  task automatic test_stall();
    bit found;
    doReset();
    run = 1; f_ready = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #1;
      if (f_valid && f_pc == 16'h8) found = 1;
    end
    total++; if (!found) begin bad++; $display("FAIL stall_reach got=timeout want=f_pc 8"); end
    f_ready = 0; #1;
    total++; if (im_addr !== 16'h0) begin bad++; $display("FAIL stall_imaddr0 got=%h want=0", im_addr); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      total++;
      if (f_valid !== 1'b1 || f_pc !== 16'h8 || f_instr !== mem[2] || im_addr !== 16'h0) begin
        bad++; $display("FAIL stall_hold%0d got=%b/%h/%h/%h want=1/8/%h/0", i, f_valid, f_pc, f_instr, im_addr, mem[2]);
      end
    end
    @(negedge clk);
    f_ready = 1; #1;
    total++; if (im_addr !== 16'h3) begin bad++; $display("FAIL stall_release_addr got=%h want=3", im_addr); end
    @(negedge clk); #1;
    total++; if (f_valid !== 1'b1 || f_pc !== 16'hC || f_instr !== mem[3]) begin bad++; $display("FAIL stall_next got=%b/%h/%h want=1/c/%h", f_valid, f_pc, f_instr, mem[3]); end
  endtask

  task automatic test_redirect();
    bit found;
    doReset();
    run = 1; f_ready = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #1;
      if (f_valid && f_pc == 16'h10) found = 1;
    end
    total++; if (!found) begin bad++; $display("FAIL redir_reach got=timeout want=f_pc 10"); end
    redirect_valid = 1; redirect_pc = 16'h34;
    @(negedge clk);
    redirect_valid = 0; #1;
    total++; if (f_valid !== 1'b0) begin bad++; $display("FAIL redir_bubble got=%b want=0", f_valid); end
    @(negedge clk); #1;
    total++; if (f_valid !== 1'b1 || f_pc !== 16'h34 || f_instr !== mem[13]) begin bad++; $display("FAIL redir_target got=%b/%h/%h want=1/34/%h", f_valid, f_pc, f_instr, mem[13]); end
  endtask

  // Model: decode must see the program in order from the last redirect target, one word per handshake.
  task automatic test_random_model();
    logic [15:0] expPc, prevPc, prevDbgAddr;
    logic [31:0] prevInstr;
    bit prevStall, prevRedir, prevDbg;
    int faultCycles;
    doReset();
    run = 1;
    expPc = 16'h0; prevPc = 0; prevInstr = 0; prevDbgAddr = 0;
    prevStall = 0; prevRedir = 0; prevDbg = 0; faultCycles = 0;
    for (int cyc = 0; cyc < 800 && faultCycles < 3; cyc++) begin
      @(negedge clk);
      f_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = (cyc < 300) && (state == 2'b01) && ($urandom_range(0, 15) == 0);
      redirect_pc = 16'($urandom_range(0, 27) * 4);
      dbg_req = $urandom_range(0, 1) == 1;
      dbg_addr = 16'($urandom_range(0, 40));
      if (faultCycles > 0) begin f_ready = 1; redirect_valid = 0; end
      #1;
      if (dbg_ack) begin
        total++;
        if (!prevDbg || dbg_rdata !== romWord(prevDbgAddr)) begin
          bad++; $display("FAIL rnd_dbg got=%h req=%b want=%h", dbg_rdata, prevDbg, romWord(prevDbgAddr));
        end
      end
      if (prevRedir) begin
        total++; if (f_valid !== 1'b0) begin bad++; $display("FAIL rnd_squash got=%b want=0", f_valid); end
      end else if (prevStall) begin
        total++;
        if (f_valid !== 1'b1 || f_pc !== prevPc || f_instr !== prevInstr) begin
          bad++; $display("FAIL rnd_hold got=%b/%h/%h want=1/%h/%h", f_valid, f_pc, f_instr, prevPc, prevInstr);
        end
      end
      if (f_valid && f_ready) begin
        total++;
        if (f_pc !== expPc || f_instr !== romWord(expPc >> 2)) begin
          bad++; $display("FAIL rnd_deliver got=%h/%h want=%h/%h", f_pc, f_instr, expPc, romWord(expPc >> 2));
        end
        expPc = expPc + 16'h4;
      end
      if (redirect_valid) expPc = redirect_pc;
      prevStall = f_valid && !f_ready;
      prevPc = f_pc; prevInstr = f_instr;
      prevRedir = redirect_valid;
      prevDbg = dbg_req; prevDbgAddr = dbg_addr;
      if (state == 2'b10) faultCycles++;
    end
    dbg_req = 0;
    total++; if (state !== 2'b10 || fault !== 1'b1) begin bad++; $display("FAIL rnd_endfault got=%b/%b want=10/1", state, fault); end
    total++; if (expPc !== 16'h80 || f_valid !== 1'b0) begin bad++; $display("FAIL rnd_drained got=%h/%b want=80/0", expPc, f_valid); end
  endtask

  task automatic test_fault_recover();
    @(negedge clk);
    clear_fault = 1; run = 0; f_ready = 1;
    @(negedge clk);
    clear_fault = 0; #1;
    total++; if (state !== 2'b00 || fault !== 1'b0) begin bad++; $display("FAIL recover_halt got=%b/%b want=00/0", state, fault); end
    redirect_valid = 1; redirect_pc = 16'h0; run = 1;
    @(negedge clk);
    redirect_valid = 0; #1;
    total++; if (state !== 2'b01 || im_addr !== 16'h0) begin bad++; $display("FAIL recover_run got=%b/%h want=01/0", state, im_addr); end
    @(negedge clk); #1;
    total++; if (f_valid !== 1'b1 || f_pc !== 16'h0 || f_instr !== mem[0]) begin bad++; $display("FAIL recover_fetch got=%b/%h/%h want=1/0/%h", f_valid, f_pc, f_instr, mem[0]); end
  endtask

  task automatic test_misaligned();
    doReset();
    redirect_valid = 1; redirect_pc = 16'h20;
    @(negedge clk);
    redirect_pc = 16'h06;
    @(negedge clk);
    redirect_valid = 0; #1;
    total++; if (state !== 2'b10 || fault !== 1'b1) begin bad++; $display("FAIL misalign_fault got=%b/%b want=10/1", state, fault); end
    clear_fault = 1;
    @(negedge clk);
    clear_fault = 0; run = 1; f_ready = 1;
    @(negedge clk); #1;
    total++; if (im_addr !== 16'h8) begin bad++; $display("FAIL misalign_pc got=%h want=8", im_addr); end
    @(negedge clk); #1;
    total++; if (f_valid !== 1'b1 || f_pc !== 16'h20 || f_instr !== mem[8]) begin bad++; $display("FAIL misalign_fetch got=%b/%h/%h want=1/20/%h", f_valid, f_pc, f_instr, mem[8]); end
  endtask

  task automatic test_debug();
    doReset();
    dbg_req = 1; dbg_addr = 16'h5; #1;
    total++; if (im_addr !== 16'h5 || dbg_ack !== 1'b0) begin bad++; $display("FAIL dbg_addr got=%h/%b want=5/0", im_addr, dbg_ack); end
    @(negedge clk);
    dbg_req = 0; #1;
    total++; if (dbg_ack !== 1'b1 || dbg_rdata !== mem[5]) begin bad++; $display("FAIL dbg_read got=%b/%h want=1/%h", dbg_ack, dbg_rdata, mem[5]); end
    @(negedge clk); #1;
    total++; if (dbg_ack !== 1'b0) begin bad++; $display("FAIL dbg_pulse got=%b want=0", dbg_ack); end
  endtask

  task automatic test_debug_starve();
    bit found;
    doReset();
    run = 1; f_ready = 1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk); #1;
      if (f_valid) found = 1;
    end
    total++; if (!found) begin bad++; $display("FAIL starve_reach got=timeout want=f_valid"); end
    dbg_req = 1; dbg_addr = 16'h7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      total++; if (dbg_ack !== 1'b0) begin bad++; $display("FAIL starve_noack%0d got=%b want=0", i, dbg_ack); end
    end
    @(negedge clk);
    f_ready = 0; #1;
    @(negedge clk);
    dbg_req = 0; #1;
    total++; if (dbg_ack !== 1'b1 || dbg_rdata !== mem[7]) begin bad++; $display("FAIL starve_grant got=%b/%h want=1/%h", dbg_ack, dbg_rdata, mem[7]); end
  endtask

  task automatic test_reset_async();
    bit found;
    doReset();
    run = 1; f_ready = 1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk); #1;
      if (f_valid && f_pc == 16'h8) found = 1;
    end
    total++; if (!found) begin bad++; $display("FAIL arst_reach got=timeout want=f_pc 8"); end
    f_ready = 0;
    @(negedge clk); #1;
    total++; if (f_valid !== 1'b1) begin bad++; $display("FAIL arst_stall got=%b want=1", f_valid); end
    rst = 1; #1;
    total++; if (f_valid !== 1'b0 || state !== 2'b00 || dbg_ack !== 1'b0) begin bad++; $display("FAIL arst_immediate got=%b/%b/%b want=0/00/0", f_valid, state, dbg_ack); end
    @(negedge clk);
    rst = 0; f_ready = 1;
    @(negedge clk); #1;
    total++; if (im_addr !== 16'h0) begin bad++; $display("FAIL arst_pc got=%h want=0", im_addr); end
    @(negedge clk); #1;
    total++; if (f_valid !== 1'b1 || f_pc !== 16'h0) begin bad++; $display("FAIL arst_fetch got=%b/%h want=1/0", f_valid, f_pc); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0;
    bad = 0;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_random_model();
    test_fault_recover();
    test_misaligned();
    test_debug();
    test_debug_starve();
    test_reset_async();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
